// File: rtl/pedometer_pkg.sv
// Shared pedometer definitions: node sample width, detector state encoding and
// default gait thresholds.
package pedometer_pkg;

  localparam int unsigned NodeW = 10;

  localparam logic [NodeW-1:0] DefThrHigh = 10'd600;
  localparam logic [NodeW-1:0] DefThrLow  = 10'd400;

  typedef enum logic [0:0] {
    StLow,
    StHigh
  } det_state_e;

endpackage

// File: rtl/sat_counter.sv
// Width-parameterised saturating up-counter with synchronous clear and a sticky
// flag that sets on the increment that reaches all-ones.
module sat_counter #(
  parameter int unsigned Width = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [Width-1:0] cnt_o,
  output logic             sat_o
);

  localparam logic [Width-1:0] CntMax   = {Width{1'b1}};
  localparam logic [Width-1:0] CntMaxM1 = {{(Width - 1){1'b1}}, 1'b0};

  logic [Width-1:0] cnt_d, cnt_q;
  logic             sat_d, sat_q;

  always_comb begin
    cnt_d = cnt_q;
    sat_d = sat_q;
    if (clr_i) begin
      cnt_d = '0;
      sat_d = 1'b0;
    end else if (inc_i) begin
      if (cnt_q != CntMax) begin
        cnt_d = cnt_q + 1'b1;
      end
      if (cnt_q == CntMaxM1) begin
        sat_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      sat_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      sat_q <= sat_d;
    end
  end

  assign cnt_o = cnt_q;
  assign sat_o = sat_q;

endmodule

// File: rtl/node_step_detector.sv
// Gait step detector: hysteresis comparator on the node sample stream with a
// minimum inter-step gap, saturating step count and registered pulses.
module node_step_detector
  import pedometer_pkg::*;
#(
  parameter int unsigned NODE_W  = NodeW,
  parameter int unsigned CNT_W   = 16,
  parameter int unsigned MIN_GAP = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NODE_W-1:0] node_result,
  input  logic              node_valid,
  input  logic [NODE_W-1:0] thr_high,
  input  logic [NODE_W-1:0] thr_low,
  input  logic              clear,
  output logic [CNT_W-1:0]  step_count,
  output logic              step_pulse,
  output logic              reject_pulse,
  output logic              count_sat
);

  localparam int unsigned     GapW   = $clog2(MIN_GAP + 1);
  localparam logic [GapW-1:0] GapMax = GapW'(MIN_GAP);

  det_state_e      state_d, state_q;
  logic [GapW-1:0] gap_d, gap_q;
  logic            step_d, step_q;
  logic            rej_d, rej_q;

  logic [NODE_W-1:0] thr_lo_eff;
  logic [GapW-1:0]   gap_inc;
  logic              at_high;
  logic              below_low;

  // A low threshold above the high one collapses to a single threshold.
  assign thr_lo_eff = (thr_low < thr_high) ? thr_low : thr_high;
  assign gap_inc    = (gap_q == GapMax) ? gap_q : gap_q + 1'b1;
  assign at_high    = (node_result >= thr_high);
  assign below_low  = (node_result < thr_lo_eff);

  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    step_d  = 1'b0;
    rej_d   = 1'b0;
    if (clear) begin
      state_d = StLow;
      gap_d   = GapMax;
    end else if (node_valid) begin
      gap_d = gap_inc;
      unique case (state_q)
        StLow: begin
          if (at_high) begin
            state_d = StHigh;
            if (gap_q == GapMax) begin
              step_d = 1'b1;
              gap_d  = '0;
            end else begin
              rej_d = 1'b1;
            end
          end
        end
        StHigh: begin
          if (below_low) begin
            state_d = StLow;
          end
        end
        default: state_d = StLow;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StLow;
      gap_q   <= GapMax;
      step_q  <= 1'b0;
      rej_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      gap_q   <= gap_d;
      step_q  <= step_d;
      rej_q   <= rej_d;
    end
  end

  sat_counter #(
    .Width(CNT_W)
  ) u_step_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .clr_i(clear),
    .inc_i(step_d),
    .cnt_o(step_count),
    .sat_o(count_sat)
  );

  assign step_pulse   = step_q;
  assign reject_pulse = rej_q;

endmodule

// File: tb/tb_node_step_detector.sv
// Directed bench for node_step_detector: vector table plus hand sequences for
// saturation, clear priority and asynchronous reset.
module tb_node_step_detector;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [9:0]  node_result = '0;
  logic        node_valid = 1'b0;
  logic [9:0]  thr_high = 10'd600;
  logic [9:0]  thr_low = 10'd400;
  logic        clear = 1'b0;

  logic [15:0] step_count;
  logic        step_pulse, reject_pulse, count_sat;
  logic [3:0]  s_count;
  logic        s_step, s_rej, s_sat;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  node_step_detector #(.NODE_W(10), .CNT_W(16), .MIN_GAP(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .node_result (node_result),
    .node_valid  (node_valid),
    .thr_high    (thr_high),
    .thr_low     (thr_low),
    .clear       (clear),
    .step_count  (step_count),
    .step_pulse  (step_pulse),
    .reject_pulse(reject_pulse),
    .count_sat   (count_sat)
  );

  node_step_detector #(.NODE_W(10), .CNT_W(4), .MIN_GAP(4)) dut_s (
    .clk         (clk),
    .rst_n       (rst_n),
    .node_result (node_result),
    .node_valid  (node_valid),
    .thr_high    (thr_high),
    .thr_low     (thr_low),
    .clear       (clear),
    .step_count  (s_count),
    .step_pulse  (s_step),
    .reject_pulse(s_rej),
    .count_sat   (s_sat)
  );

  typedef struct {
    logic        valid;
    logic        clr;
    logic [9:0]  res;
    logic [9:0]  th;
    logic [9:0]  tl;
    logic        ep;
    logic        er;
    logic [15:0] ec;
  } vec_t;

  vec_t vq[$];

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic add(input logic v, input logic c, input int r, input int th, input int tl,
                     input logic ep, input logic er, input int ec);
    vec_t x;
    x.valid = v;
    x.clr   = c;
    x.res   = 10'(r);
    x.th    = 10'(th);
    x.tl    = 10'(tl);
    x.ep    = ep;
    x.er    = er;
    x.ec    = 16'(ec);
    vq.push_back(x);
  endtask

  // Apply one cycle of inputs, clock it, sample #1 after the edge.
  task automatic cyc(input logic v, input logic c, input int r);
    node_valid  = v;
    clear       = c;
    node_result = 10'(r);
    @(posedge clk);
    #1;
    node_valid  = 1'b0;
    clear       = 1'b0;
  endtask

  initial begin
    // Basic hysteresis, gap 4
    add(1, 0, 100, 600, 400, 0, 0, 0);
    add(1, 0, 700, 600, 400, 1, 0, 1);
    add(1, 0, 650, 600, 400, 0, 0, 1);
    add(1, 0, 300, 600, 400, 0, 0, 1);
    add(1, 0, 700, 600, 400, 0, 1, 1);
    add(1, 0, 300, 600, 400, 0, 0, 1);
    add(1, 0, 700, 600, 400, 1, 0, 2);
    add(0, 1, 0,   600, 400, 0, 0, 0);
    // Boundary compares
    add(1, 0, 599, 600, 400, 0, 0, 0);
    add(1, 0, 600, 600, 400, 1, 0, 1);
    add(1, 0, 400, 600, 400, 0, 0, 1);
    add(1, 0, 399, 600, 400, 0, 0, 1);
    for (int i = 0; i < 5; i++) add(1, 0, 0, 600, 400, 0, 0, 1);
    add(1, 0, 600, 600, 400, 1, 0, 2);
    // Invalid cycle is ignored, then a too-early crossing is rejected
    add(0, 0, 1000, 600, 400, 0, 0, 2);
    add(1, 0, 0,   600, 400, 0, 0, 2);
    add(1, 0, 700, 600, 400, 0, 1, 2);
    // Misconfigured thr_low > thr_high acts as a single threshold of 500
    add(0, 1, 0,   500, 800, 0, 0, 0);
    add(1, 0, 600, 500, 800, 1, 0, 1);
    add(1, 0, 550, 500, 800, 0, 0, 1);
    add(1, 0, 600, 500, 800, 0, 0, 1);
    add(1, 0, 499, 500, 800, 0, 0, 1);
    add(1, 0, 0,   500, 800, 0, 0, 1);
    add(1, 0, 500, 500, 800, 1, 0, 2);
    // Clear has priority over a coinciding sample and restores the gap
    add(0, 1, 0,    600, 400, 0, 0, 0);
    add(1, 0, 700,  600, 400, 1, 0, 1);
    add(1, 0, 300,  600, 400, 0, 0, 1);
    add(1, 1, 1000, 600, 400, 0, 0, 0);
    add(1, 0, 1000, 600, 400, 1, 0, 1);

    // Reset and idle
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_count", int'(step_count), 0);
    check("reset_sat", int'(count_sat), 0);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cyc(0, 0, 900);
      check("idle_count", int'(step_count), 0);
      check("idle_pulses", int'({step_pulse, reject_pulse, count_sat}), 0);
    end

    // Table vectors
    for (int i = 0; i < vq.size(); i++) begin
      thr_high = vq[i].th;
      thr_low  = vq[i].tl;
      cyc(vq[i].valid, vq[i].clr, int'(vq[i].res));
      check($sformatf("vec%0d_step", i), int'(step_pulse), int'(vq[i].ep));
      check($sformatf("vec%0d_rej", i), int'(reject_pulse), int'(vq[i].er));
      check($sformatf("vec%0d_count", i), int'(step_count), int'(vq[i].ec));
    end
    thr_high = 10'd600;
    thr_low  = 10'd400;

    // Saturation on the 4-bit instance
    cyc(0, 1, 0);
    for (int i = 1; i <= 16; i++) begin
      cyc(1, 0, 700);
      check($sformatf("sat%0d_step", i), int'(s_step), 1);
      check($sformatf("sat%0d_count", i), int'(s_count), (i > 15) ? 15 : i);
      check($sformatf("sat%0d_flag", i), int'(s_sat), (i >= 15) ? 1 : 0);
      for (int k = 0; k < 4; k++) cyc(1, 0, 0);
    end
    check("sat_wide_count", int'(step_count), 16);
    check("sat_wide_flag", int'(count_sat), 0);
    cyc(0, 1, 0);
    check("sat_clear_count", int'(s_count), 0);
    check("sat_clear_flag", int'(s_sat), 0);

    // Asynchronous reset while HIGH, right after the third step
    for (int i = 0; i < 3; i++) begin
      cyc(1, 0, 700);
      if (i < 2) for (int k = 0; k < 4; k++) cyc(1, 0, 0);
    end
    check("pre_rst_count", int'(step_count), 3);
    check("pre_rst_step", int'(step_pulse), 1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_count", int'(step_count), 0);
    check("async_rst_step", int'(step_pulse), 0);
    check("async_rst_sat", int'(s_sat), 0);
    #1 rst_n = 1'b1;
    @(negedge clk);
    cyc(1, 0, 700);
    check("post_rst_step", int'(step_pulse), 1);
    check("post_rst_count", int'(step_count), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/node_step_detector.md
Name: node_step_detector

Overview:
- Consumes the 10-bit node output stream, one weighted-sum value per valid sample.
- Detects gait peaks with a two-threshold hysteresis comparator and a minimum inter-step gap.
- Maintains a saturating step count and emits per-step and per-reject pulses.
- Sits directly downstream of the node datapath and feeds the pedometer's step register and software-visible counters.

Parameters:
NODE_W, 10, width of node_result and both thresholds
CNT_W, 16, width of step_count
MIN_GAP, 8, accepted samples required after a counted step before another step may be counted (legal range 1..255)

Ports:
clk  input  1  clock, all state updates on rising edge
rst_n  input  1  reset, asynchronous, active-low
node_result  input  NODE_W  node output sample, unsigned
node_valid  input  1  node_result valid this cycle; every asserted cycle is accepted (no backpressure)
thr_high  input  NODE_W  rising threshold, quasi-static
thr_low  input  NODE_W  falling threshold, quasi-static
clear  input  1  synchronous clear of count and detector state
step_count  output  CNT_W  number of counted steps, saturating
step_pulse  output  1  one-cycle pulse, step counted
reject_pulse  output  1  one-cycle pulse, threshold crossing rejected by the gap rule
count_sat  output  1  sticky flag, step_count has reached all-ones

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=LOW, step_count=0, gap_cnt=MIN_GAP, step_pulse=0, reject_pulse=0, count_sat=0.
  - Reset mid-stream discards everything; the first sample after release is treated as fresh.
- Effective low threshold: thr_lo_eff = min(thr_low, thr_high). A misconfigured thr_low > thr_high therefore degrades to a single threshold.
- gap_cnt: internal, ceil(log2(MIN_GAP+1)) bits, saturates at MIN_GAP.
- FSM states LOW and HIGH. Evaluated only on cycles with node_valid=1 and clear=0:
  - LOW, node_result >= thr_high, gap_cnt == MIN_GAP: go to HIGH; step counted; gap_cnt <= 0.
  - LOW, node_result >= thr_high, gap_cnt < MIN_GAP: go to HIGH; reject_pulse; gap_cnt increments.
  - LOW, otherwise: stay LOW; gap_cnt increments (saturating).
  - HIGH, node_result < thr_lo_eff: go to LOW; gap_cnt increments.
  - HIGH, otherwise: stay HIGH; gap_cnt increments.
- Compare boundaries: equality to thr_high counts as a crossing; equality to thr_lo_eff does not fall.
- Step counted:
  - step_count <= step_count+1, saturating at all-ones.
  - step_pulse=1 in the cycle after the sample edge (registered, latency 1).
  - When the increment reaches all-ones, count_sat sets and stays set until clear or reset.
  - Once saturated, further steps still pulse step_pulse; the count holds.
- reject_pulse is registered with the same latency; step_pulse and reject_pulse are never both high.
- node_valid=0: no state, counter or gap change; both pulses deassert next cycle.
- clear=1 (synchronous, priority over node_valid):
  - state=LOW, step_count=0, gap_cnt=MIN_GAP, count_sat=0, pulses 0.
  - A sample coinciding with clear is dropped.
- Threshold changes take effect on the next accepted sample; no retroactive re-evaluation.
- All outputs are registered; no combinational path from inputs to outputs.

Decomposition:
- Shared package pedometer_pkg:
  - NODE_W=10 (shared with the node datapath).
  - Detector state enum {LOW, HIGH}.
  - Default threshold constants.
- One natural sub-module: sat_counter (width-parameterised saturating up-counter with sync clear and a saturate flag), instantiated for step_count. gap_cnt stays inline.

Test Plan:
- Reset/idle: hold rst_n low 3 cycles, then node_valid=0 for 10 cycles -> step_count=0, pulses 0, count_sat=0 throughout.
- Basic hysteresis: MIN_GAP=4, thr_high=600, thr_low=400, samples 100,700,650,300,700,300,700 -> step_pulse after samples 2 and 7, reject_pulse after sample 5, final step_count=2.
- Boundary compare: samples 599 -> no step; 600 -> step; 400 (stays HIGH); 399 -> LOW. Then 5 samples of 0 followed by 600 -> second step, count=2.
- Saturation: CNT_W=4, 16 spaced valid steps -> count reaches 15 at step 15 with count_sat=1; step 16 pulses, count stays 15.
- Clear priority: clear=1 with node_valid=1, node_result=1000 while in LOW -> no step, count=0. The next sample 1000 counts immediately (gap reset to MIN_GAP).
- Async reset mid-HIGH: count=3, state HIGH, drop rst_n between edges -> outputs 0 immediately. After release, 700 counts as a step (count=1).
